// File: rtl/rf_wport_arbiter.sv
// Two-source arbiter for the register-file write port: picks one writeback
// per cycle, drives the write-enable decoder with a registered pulse, counts conflicts.
module rf_wport_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 4,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStall,
    input  logic        iReq0Valid,
    input  logic [4:0]  iReq0Addr,
    input  logic [31:0] iReq0Data,
    output logic        oReq0Ready,
    input  logic        iReq1Valid,
    input  logic [4:0]  iReq1Addr,
    input  logic [31:0] iReq1Data,
    output logic        oReq1Ready,
    output logic [4:0]  oDecAddr,
    output logic        oDecEna,
    output logic [31:0] oWrData,
    output logic        oLastGrant,
    output logic [15:0] oConflictCnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [4:0]  dec_addr_q, dec_addr_d;
    logic        dec_ena_q, dec_ena_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic        both_s;
    logic        gnt0_s, gnt1_s;
    logic        xfer_s;
    logic [4:0]  sel_addr_s;
    logic [31:0] sel_data_s;

    // Grant selection; readies are forced low while reset or stall is asserted.
    always_comb begin
        both_s = iReq0Valid & iReq1Valid;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!iRst_n || iStall) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (both_s) begin
            if (PRIORITY_MODE == 0) begin
                gnt0_s = last_grant_q;
                gnt1_s = ~last_grant_q;
            end else begin
                gnt1_s = (wait_q == MAX_WAIT_C);
                gnt0_s = ~gnt1_s;
            end
        end else begin
            gnt0_s = iReq0Valid;
            gnt1_s = iReq1Valid;
        end
    end

    assign oReq0Ready = gnt0_s;
    assign oReq1Ready = gnt1_s;

    // Next-state computation for the write pipeline, wait counter and conflict counter.
    always_comb begin
        xfer_s         = gnt0_s | gnt1_s;
        sel_addr_s     = gnt1_s ? iReq1Addr : iReq0Addr;
        sel_data_s     = gnt1_s ? iReq1Data : iReq0Data;
        dec_addr_d     = dec_addr_q;
        wr_data_d      = wr_data_q;
        last_grant_d   = last_grant_q;
        dec_ena_d      = 1'b0;
        wait_d         = wait_q;
        conflict_cnt_d = conflict_cnt_q;
        state_d        = state_q;

        if (xfer_s) begin
            dec_addr_d   = sel_addr_s;
            wr_data_d    = sel_data_s;
            last_grant_d = gnt1_s;
            dec_ena_d    = !((ZERO_SUPPRESS != 0) && (sel_addr_s == 5'd0));
        end else begin
            dec_ena_d    = 1'b0;
        end

        // Starvation guard only exists in fixed-priority mode.
        if (PRIORITY_MODE == 0) begin
            wait_d = 4'd0;
        end else if (gnt1_s) begin
            wait_d = 4'd0;
        end else if (both_s && gnt0_s && (wait_q < MAX_WAIT_C)) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end

        if (both_s && !iStall && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end

        // A suppressed $0 write lands in S_IDLE since it raises no enable.
        case (state_q)
            S_IDLE, S_WR, S_STALL: begin
                if (iStall) begin
                    state_d = S_STALL;
                end else if (dec_ena_d) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q        <= S_IDLE;
            dec_addr_q     <= 5'd0;
            dec_ena_q      <= 1'b0;
            wr_data_q      <= 32'd0;
            last_grant_q   <= 1'b1;
            wait_q         <= 4'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            dec_addr_q     <= dec_addr_d;
            dec_ena_q      <= dec_ena_d;
            wr_data_q      <= wr_data_d;
            last_grant_q   <= last_grant_d;
            wait_q         <= wait_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign oDecAddr     = dec_addr_q;
    assign oDecEna      = dec_ena_q;
    assign oWrData      = wr_data_q;
    assign oLastGrant   = last_grant_q;
    assign oConflictCnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance
// share one stimulus stream and are checked against hand-computed values.
module tb_rf_wport_arbiter;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iStall = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [4:0]  a0 = 5'd0, a1 = 5'd0;
    logic [31:0] d0 = 32'd0, d1 = 32'd0;

    logic        rr_r0, rr_r1, rr_ena, rr_last;
    logic [4:0]  rr_addr;
    logic [31:0] rr_data;
    logic [15:0] rr_cnt;
    logic        pr_r0, pr_r1, pr_ena, pr_last;
    logic [4:0]  pr_addr;
    logic [31:0] pr_data;
    logic [15:0] pr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 iClk = ~iClk;

    rf_wport_arbiter #(.PRIORITY_MODE(0), .MAX_WAIT(4), .ZERO_SUPPRESS(1)) u_rr (
        .iClk(iClk), .iRst_n(iRst_n), .iStall(iStall),
        .iReq0Valid(v0), .iReq0Addr(a0), .iReq0Data(d0), .oReq0Ready(rr_r0),
        .iReq1Valid(v1), .iReq1Addr(a1), .iReq1Data(d1), .oReq1Ready(rr_r1),
        .oDecAddr(rr_addr), .oDecEna(rr_ena), .oWrData(rr_data),
        .oLastGrant(rr_last), .oConflictCnt(rr_cnt)
    );

    rf_wport_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(4), .ZERO_SUPPRESS(1)) u_pr (
        .iClk(iClk), .iRst_n(iRst_n), .iStall(iStall),
        .iReq0Valid(v0), .iReq0Addr(a0), .iReq0Data(d0), .oReq0Ready(pr_r0),
        .iReq1Valid(v1), .iReq1Addr(a1), .iReq1Data(d1), .oReq1Ready(pr_r1),
        .oDecAddr(pr_addr), .oDecEna(pr_ena), .oWrData(pr_data),
        .oLastGrant(pr_last), .oConflictCnt(pr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst_n = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state while reset is held from time zero
        #7;
        chk("rst_ena", 32'(rr_ena), 32'd0);
        chk("rst_last", 32'(rr_last), 32'd1);
        chk("rst_cnt", 32'(rr_cnt), 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        tick();

        // Single write from port 0
        v0 = 1'b1; a0 = 5'd9; d0 = 32'hDEADBEEF;
        #1;
        chk("single_rdy0", 32'(rr_r0), 32'd1);
        tick();
        v0 = 1'b0;
        chk("single_addr", 32'(rr_addr), 32'd9);
        chk("single_ena", 32'(rr_ena), 32'd1);
        chk("single_data", rr_data, 32'hDEADBEEF);
        tick();
        chk("single_ena_drop", 32'(rr_ena), 32'd0);
        chk("single_last", 32'(rr_last), 32'd0);

        // $zero suppression on port 1
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h12345678;
        #1;
        chk("zero_rdy1", 32'(rr_r1), 32'd1);
        tick();
        v1 = 1'b0;
        chk("zero_ena", 32'(rr_ena), 32'd0);
        chk("zero_last", 32'(rr_last), 32'd1);
        chk("zero_data", rr_data, 32'h12345678);
        chk("zero_pr_ena", 32'(pr_ena), 32'd0);

        // Continuous conflict: round-robin alternates, fixed priority lets port 1 in every 5th
        do_reset();
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h0000_0001;
        v1 = 1'b1; a1 = 5'd2; d1 = 32'h0000_0002;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("rr_rdy0_c%0d", c), 32'(rr_r0), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_rdy1_c%0d", c), 32'(rr_r1), (c % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("pr_rdy1_c%0d", c), 32'(pr_r1), (c % 5 == 4) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rr_addr_c%0d", c), 32'(rr_addr), (c % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("pr_addr_c%0d", c), 32'(pr_addr), (c % 5 == 4) ? 32'd2 : 32'd1);
            if (c == 3) begin
                chk("rr_cnt_4", 32'(rr_cnt), 32'd4);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        chk("rr_cnt_10", 32'(rr_cnt), 32'd10);
        chk("pr_cnt_10", 32'(pr_cnt), 32'd10);
        chk("pr_last_10", 32'(pr_last), 32'd1);

        // Stall blocks grants for three cycles, grant as soon as it falls
        iStall = 1'b1;
        v0 = 1'b1; a0 = 5'd7; d0 = 32'hCAFE0007;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall_rdy0_%0d", s), 32'(rr_r0), 32'd0);
            tick();
            chk($sformatf("stall_ena_%0d", s), 32'(rr_ena), 32'd0);
        end
        iStall = 1'b0;
        #1;
        chk("unstall_rdy0", 32'(rr_r0), 32'd1);
        tick();
        chk("unstall_ena", 32'(rr_ena), 32'd1);
        chk("unstall_addr", 32'(rr_addr), 32'd7);
        chk("stall_cnt", 32'(rr_cnt), 32'd10);

        // Async reset while a write pulse is high
        a0 = 5'd3; d0 = 32'hA5A50003;
        tick();
        chk("pre_rst_ena", 32'(rr_ena), 32'd1);
        chk("pre_rst_addr", 32'(rr_addr), 32'd3);
        #2;
        iRst_n = 1'b0;
        #1;
        chk("arst_ena", 32'(rr_ena), 32'd0);
        chk("arst_addr", 32'(rr_addr), 32'd0);
        chk("arst_data", rr_data, 32'd0);
        chk("arst_cnt", 32'(rr_cnt), 32'd0);
        chk("arst_pr_cnt", 32'(pr_cnt), 32'd0);
        chk("arst_rdy0", 32'(rr_r0), 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;
        v1 = 1'b1; a1 = 5'd4; d1 = 32'h0000_0004;
        #1;
        chk("post_rst_rr_rdy0", 32'(rr_r0), 32'd1);
        chk("post_rst_rr_rdy1", 32'(rr_r1), 32'd0);
        chk("post_rst_pr_rdy0", 32'(pr_r0), 32'd1);
        tick();
        chk("post_rst_last", 32'(rr_last), 32'd0);
        chk("post_rst_addr", 32'(rr_addr), 32'd3);
        v0 = 1'b0; v1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
